// File: rtl/pipe_pkg.sv
// Shared types for the pipeline hazard unit: scoreboard entry layout and
// forwarding-select encodings.
package pipe_pkg;

    // Widest register address the scoreboard entry can carry; narrower
    // addresses are zero-extended into it.
    localparam int unsigned REG_AW_MAX = 8;

    localparam int unsigned FWD_RF    = 0;
    localparam int unsigned FWD_EXMEM = 1;
    localparam int unsigned FWD_MEMWB = 2;

    typedef struct packed {
        logic                  valid;
        logic [REG_AW_MAX-1:0] rd;
        logic                  we;
        logic                  is_load;
    } sb_entry_t;

endpackage

// File: rtl/hazard_match.sv
// Per-operand producer match against the scoreboard: raises the stall request
// and encodes the youngest forwardable producer as a select.
module hazard_match
    import pipe_pkg::*;
#(
    parameter int unsigned DEPTH       = 3,
    parameter int unsigned REG_AW      = 3,
    parameter int unsigned LOAD_LAT    = 1,
    parameter int unsigned FORWARD_EN  = 1,
    parameter int unsigned ZERO_REG_EN = 0,
    parameter int unsigned SEL_W       = $clog2(DEPTH)
) (
    input  sb_entry_t         slots_i [DEPTH],
    input  logic [REG_AW-1:0] src_i,
    input  logic              use_i,
    input  logic              id_valid_i,
    output logic              stall_o,
    output logic [SEL_W-1:0]  sel_o
);

    logic reads;
    logic hit;
    logic found;

    assign reads = use_i && id_valid_i && !((ZERO_REG_EN != 0) && (src_i == '0));

    // Slot index j here is pipeline slot j+1; the first hit seen is the youngest.
    always_comb begin
        stall_o = 1'b0;
        sel_o   = SEL_W'(FWD_RF);
        found   = 1'b0;
        hit     = 1'b0;
        for (int unsigned j = 0; j < DEPTH; j++) begin
            hit = reads && slots_i[j].valid && slots_i[j].we &&
                  (slots_i[j].rd == REG_AW_MAX'(src_i));
            if (FORWARD_EN != 0) begin
                if (hit && slots_i[j].is_load && (j < LOAD_LAT)) begin
                    stall_o = 1'b1;
                end
                if (hit && !found && (j < DEPTH - 1)) begin
                    sel_o = SEL_W'(FWD_EXMEM + j);
                end
            end else if (hit) begin
                stall_o = 1'b1;
            end
            if (hit) begin
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/pipe_hazard_unit.sv
// Hazard detection and forwarding controller beside ID: tracks in-flight
// producers, issues stalls/flushes and registers EX forwarding selects.
module pipe_hazard_unit
    import pipe_pkg::*;
#(
    parameter int unsigned REG_AW      = 3,
    parameter int unsigned DEPTH       = 3,
    parameter int unsigned LOAD_LAT    = 1,
    parameter int unsigned FORWARD_EN  = 1,
    parameter int unsigned ZERO_REG_EN = 0,
    parameter int unsigned CNT_W       = 16,
    localparam int unsigned SEL_W      = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic              id_use_rs1,
    input  logic              id_use_rs2,
    input  logic [REG_AW-1:0] id_rd,
    input  logic              id_we,
    input  logic              id_is_load,
    input  logic              flush_i,
    output logic              stall_o,
    output logic              bubble_o,
    output logic              flush_if_id_o,
    output logic              flush_id_ex_o,
    output logic              flush_ex_mem_o,
    output logic [SEL_W-1:0]  fwd_a_o,
    output logic [SEL_W-1:0]  fwd_b_o,
    output logic [CNT_W-1:0]  stall_cnt_o,
    output logic [CNT_W-1:0]  flush_cnt_o
);

    sb_entry_t        slots_q [DEPTH];
    sb_entry_t        slot1_d;
    logic             stall_a, stall_b, hazard, enter_ex;
    logic [SEL_W-1:0] sel_a, sel_b;
    logic [SEL_W-1:0] fwd_a_q, fwd_b_q;
    logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;

    hazard_match #(
        .DEPTH(DEPTH), .REG_AW(REG_AW), .LOAD_LAT(LOAD_LAT),
        .FORWARD_EN(FORWARD_EN), .ZERO_REG_EN(ZERO_REG_EN), .SEL_W(SEL_W)
    ) u_match_rs1 (
        .slots_i(slots_q), .src_i(id_rs1), .use_i(id_use_rs1),
        .id_valid_i(id_valid), .stall_o(stall_a), .sel_o(sel_a)
    );

    hazard_match #(
        .DEPTH(DEPTH), .REG_AW(REG_AW), .LOAD_LAT(LOAD_LAT),
        .FORWARD_EN(FORWARD_EN), .ZERO_REG_EN(ZERO_REG_EN), .SEL_W(SEL_W)
    ) u_match_rs2 (
        .slots_i(slots_q), .src_i(id_rs2), .use_i(id_use_rs2),
        .id_valid_i(id_valid), .stall_o(stall_b), .sel_o(sel_b)
    );

    // Flush outranks stall: a squashed ID never stalls and never enters EX.
    assign hazard         = stall_a | stall_b;
    assign stall_o        = hazard & ~flush_i;
    assign bubble_o       = stall_o;
    assign flush_if_id_o  = flush_i;
    assign flush_id_ex_o  = flush_i;
    assign flush_ex_mem_o = flush_i;
    assign enter_ex       = id_valid & ~hazard & ~flush_i;

    always_comb begin
        slot1_d         = '0;
        slot1_d.valid   = enter_ex;
        slot1_d.rd      = REG_AW_MAX'(id_rd);
        slot1_d.we      = id_we;
        slot1_d.is_load = id_is_load;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int unsigned j = 0; j < DEPTH; j++) begin
                slots_q[j] <= '0;
            end
            fwd_a_q     <= SEL_W'(FWD_RF);
            fwd_b_q     <= SEL_W'(FWD_RF);
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            slots_q[0] <= slot1_d;
            // Slot 2 receives the instruction squashed out of EX on a flush.
            if (flush_i) begin
                slots_q[1] <= '0;
            end else begin
                slots_q[1] <= slots_q[0];
            end
            for (int unsigned j = 2; j < DEPTH; j++) begin
                slots_q[j] <= slots_q[j-1];
            end
            fwd_a_q <= enter_ex ? sel_a : SEL_W'(FWD_RF);
            fwd_b_q <= enter_ex ? sel_b : SEL_W'(FWD_RF);
            if (stall_o && (stall_cnt_q != '1)) begin
                stall_cnt_q <= stall_cnt_q + 1'b1;
            end
            if (flush_i && (flush_cnt_q != '1)) begin
                flush_cnt_q <= flush_cnt_q + 1'b1;
            end
        end
    end

    assign fwd_a_o     = fwd_a_q;
    assign fwd_b_o     = fwd_b_q;
    assign stall_cnt_o = stall_cnt_q;
    assign flush_cnt_o = flush_cnt_q;

endmodule

// File: doc/pipe_hazard_unit.md
Name: pipe_hazard_unit

Overview:
Parametrised hazard-detection and forwarding controller for the in-order 16-bit five-stage pipeline (IF, ID, EX, MEM, WB).
- Sits beside the ID stage and keeps an internal scoreboard of the instructions in flight after ID.
- Issues load-use / no-forward stalls, branch flushes and registered forwarding selects that are aligned with the ID/EX register.
- Adds data-hazard and control-hazard handling the current pipeline lacks; depth, register count, load latency and forwarding mode are configurable.

Parameters:
REG_AW, 3, register address width; register file holds 2**REG_AW entries.
DEPTH, 3, tracked stages after ID (slot 1 = EX, slot 2 = MEM, slot DEPTH = WB); legal range 2..6.
LOAD_LAT, 1, extra cycles before load data can be forwarded; legal range 1..DEPTH-1.
FORWARD_EN, 1, 1 = forward from pipeline registers; 0 = stall until the producer has retired.
ZERO_REG_EN, 0, 1 = register 0 is hard-wired and never causes a hazard.
CNT_W, 16, width of the performance counters.

Ports:
clk  in  1  clock; all state updates on the rising edge.
rst_n  in  1  reset, synchronous, active-low.
id_valid  in  1  ID holds a real instruction.
id_rs1  in  REG_AW  source register A.
id_rs2  in  REG_AW  source register B.
id_use_rs1  in  1  instruction reads rs1.
id_use_rs2  in  1  instruction reads rs2.
id_rd  in  REG_AW  destination register.
id_we  in  1  instruction writes rd.
id_is_load  in  1  instruction is a memory load.
flush_i  in  1  branch taken, resolved in MEM (pcsrc).
stall_o  out  1  hold PC and IF/ID; combinational.
bubble_o  out  1  load a NOP into ID/EX; combinational.
flush_if_id_o  out  1  squash IF/ID; combinational, equals flush_i.
flush_id_ex_o  out  1  squash ID/EX; combinational, equals flush_i.
flush_ex_mem_o  out  1  squash EX/MEM; combinational, equals flush_i.
fwd_a_o  out  clog2(DEPTH)  registered select for ALU operand A in EX. 0 = register file; k = pipeline register after slot k.
fwd_b_o  out  clog2(DEPTH)  same encoding for operand B.
stall_cnt_o  out  CNT_W  saturating count of stall cycles.
flush_cnt_o  out  CNT_W  saturating count of flush events.

Behaviour:
- Scoreboard: DEPTH slots, each {valid, rd, we, is_load}. Every clock the slots shift: slot j+1 <= slot j; slot DEPTH is discarded.
- Slot 1 input:
  - ID entry if id_valid and no stall and no flush;
  - invalid otherwise.
- Producer match for source s at slot j: slot valid & we & rd==s & use_s & id_valid, and not (ZERO_REG_EN & s==0).
- Stall conditions, FORWARD_EN=1: any match at slot j where slot is_load and j <= LOAD_LAT.
- Stall conditions, FORWARD_EN=0: any match in any slot 1..DEPTH. The register file is not write-through, so a WB-slot producer also stalls for 1 cycle.
- stall_o = bubble_o = stall condition & ~flush_i.
- Forward select:
  - the youngest matching slot j with 1 <= j <= DEPTH-1 gives select j;
  - a match only in slot DEPTH, or no match, gives 0.
  - Selects are registered into fwd_*_o on the edge where the instruction enters EX.
  - Bubble or flush registers 0.
  - Forced to 0 when FORWARD_EN=0.
- Flush: flush_i overrides stall.
  - On the edge: slot 1 and slot 2 become invalid (slot 2 receives the squashed EX instruction); slot 3 onward shifts normally.
  - The branch itself is in slot 2 on the flush cycle and moves on to slot 3 unaffected.
- Counters:
  - stall_cnt increments on each cycle with stall_o=1; flush_cnt increments on each cycle with flush_i=1.
  - Both saturate at all-ones, with no wrap.
- Reset (rst_n=0 at edge): all slots invalid; fwd_a_o=fwd_b_o=0; counters 0. Combinational outputs follow the invalid scoreboard, so stall_o=0.
- Reset asserted mid-stall clears the stall on the next cycle; no partial state is kept.
- Simultaneous rs1 and rs2 hazards on different slots: the stall is the OR of both; each operand gets its own select.
- id_valid=0: no stall, no slot entry, selects 0.

Decomposition:
- Shared package pipe_pkg holds:
  - scoreboard entry struct {valid, rd, we, is_load};
  - forwarding-select constants FWD_RF=0, FWD_EXMEM=1, FWD_MEMWB=2.
- One sub-module: hazard_match, a combinational per-operand match and youngest-select encoder, instantiated twice (rs1, rs2).
- Scoreboard, counters and the flush/stall priority stay in the top.

Test Plan:
1. ADD r1 followed by SUB r2,r1,r3 (FORWARD_EN=1) -> no stall; fwd_a_o=1 in SUB's EX cycle.
2. ADD r1; NOP; SUB using r1 -> fwd_a_o=2. ADD r1; NOP; NOP; SUB using r1 -> fwd_a_o=0.
3. LW r4 then ADD r5,r4,r4 -> stall_o=bubble_o=1 for exactly 1 cycle, then fwd_a_o=fwd_b_o=2; stall_cnt_o=1.
4. FORWARD_EN=0, ADD r1 then dependent instruction -> stall_o high for 3 consecutive cycles (DEPTH=3), then fwd 0; stall_cnt_o=3.
5. flush_i pulse in the same cycle as a load-use stall -> stall_o=0, all three flush outputs 1; slots 1–2 invalid next cycle; flush_cnt_o=1.
6. Force stall for 2**16+5 cycles -> stall_cnt_o holds 16'hFFFF. Then rst_n=0 for one edge -> counters 0, fwd 0, stall_o 0.
